multi_servo_tester: RTL and testbench

Parametrised N-channel servo pulse generator with a button-style control front end, successor to the single-channel tester. One shared frame timer drives CHANNELS PWM outputs. Each output's pulse width comes from a per-channel target register adjusted by step pulses, clamped to a safe range, and slew-limited once per frame. Sits between the debouncers (single-cycle step/select pulses) and the servo header pins.

---
 rtl/multi_servo_tester.sv | 146 ++++++++++++++
 tb/tb_multi_servo_tester.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_servo_tester.sv
// Multi-channel servo pulse generator with a step/select control front end.
// A shared microsecond prescaler and frame counter drive CHANNELS PWM pins.
// Each channel has a target width, adjusted by step pulses and clamped to
// [MIN_US, MAX_US]. Each channel also has an applied width (cur), which
// follows the target only at frame boundaries, optionally slew-limited.
module multi_servo_tester #(
  parameter int CHANNELS  = 4,
  parameter int CLK_MHZ   = 100,
  parameter int FRAME_US  = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int CENTER_US = 1500,
  parameter int STEP_US   = 100,
  parameter int SLEW_US   = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                step_up,
  input  logic                step_dn,
  input  logic                ch_next,
  output logic [CHANNELS-1:0] CONTROL_PINS,
  output logic [3:0]          SEL,
  output logic [15:0]         PULSE_LEN
);

  localparam int               PRE_W      = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_MHZ - 1);
  localparam logic [15:0]      FRAME_LAST = 16'(FRAME_US - 1);
  localparam logic [15:0]      MIN16      = 16'(MIN_US);
  localparam logic [15:0]      MAX16      = 16'(MAX_US);
  localparam logic [15:0]      CENTER16   = 16'(CENTER_US);
  localparam logic [15:0]      STEP16     = 16'(STEP_US);
  localparam logic [15:0]      SLEW16     = 16'(SLEW_US);
  localparam logic [16:0]      MIN17      = 17'(MIN_US);
  localparam logic [16:0]      MAX17      = 17'(MAX_US);
  localparam logic [16:0]      STEP17     = 17'(STEP_US);
  localparam logic [3:0]       LAST_CH    = 4'(CHANNELS - 1);

  logic [PRE_W-1:0]    prescaler;
  logic [15:0]         frame_us;
  logic                us_tick;
  logic                frame_end;
  logic [15:0]         target      [CHANNELS];
  logic [15:0]         cur         [CHANNELS];
  logic [15:0]         target_next [CHANNELS];
  logic [15:0]         cur_next    [CHANNELS];
  logic [CHANNELS-1:0] pins_next;
  logic [15:0]         sel_len;

  // Clamped step of one target. A 17-bit sum keeps the upper compare free of
  // wrap, and the lower bound is compared before subtracting so no underflow.
  function automatic logic [15:0] step_target(input logic [15:0] t,
                                               input logic up,
                                               input logic dn);
    logic [16:0] wide;
    wide        = {1'b0, t};
    step_target = t;
    if (up && !dn) begin
      step_target = (wide + STEP17 > MAX17) ? MAX16 : t + STEP16;
    end else if (dn && !up) begin
      step_target = (wide >= MIN17 + STEP17) ? t - STEP16 : MIN16;
    end
  endfunction

  // Move the applied width toward the target by at most SLEW_US (0 = jump).
  function automatic logic [15:0] slew_toward(input logic [15:0] t,
                                              input logic [15:0] c);
    slew_toward = c;
    if (SLEW_US == 0) begin
      slew_toward = t;
    end else if (t > c) begin
      slew_toward = (t - c > SLEW16) ? c + SLEW16 : t;
    end else if (c > t) begin
      slew_toward = (c - t > SLEW16) ? c - SLEW16 : t;
    end
  endfunction

  assign us_tick   = (prescaler == PRE_LAST);
  assign frame_end = us_tick && (frame_us == FRAME_LAST);

  // Next-state values for the per-channel registers, the pins and the readback mux.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    sel_len   = '0;
    pins_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      target_next[i] = (SEL == 4'(i)) ? step_target(target[i], step_up, step_dn)
                                      : target[i];
      cur_next[i]    = slew_toward(target[i], cur[i]);
      pins_next[i]   = (frame_us < cur[i]);
      if (SEL == 4'(i)) sel_len = target[i];
    end
  end

  // Shared microsecond prescaler and frame position counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: sequential state always uses non-blocking assignments, so every
      // register samples pre-edge values regardless of block ordering.
      prescaler <= '0;
      frame_us  <= '0;
    end else begin
      prescaler <= us_tick ? '0 : prescaler + 1'b1;
      if (us_tick) frame_us <= frame_end ? '0 : frame_us + 16'd1;
    end
  end

  // Per-channel target and applied widths. Applied width moves only at frame end.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: this is a small flop array rather than a RAM, and every entry
      // must come up centred, so the whole array is reset.
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= CENTER16;
        cur[i]    <= CENTER16;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        target[i] <= target_next[i];
        if (frame_end) cur[i] <= cur_next[i];
      end
    end
  end

  // Channel selection and selected-target readback (uses the pre-edge SEL for steps).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEL       <= '0;
      PULSE_LEN <= CENTER16;
    end else begin
      if (ch_next) SEL <= (SEL == LAST_CH) ? 4'd0 : SEL + 4'd1;
      PULSE_LEN <= sel_len;
    end
  end

  // Registered servo outputs; high while the frame position is below the applied width.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CONTROL_PINS <= '0;
    end else begin
      CONTROL_PINS <= pins_next;
    end
  end

endmodule

// File: tb/tb_multi_servo_tester.sv
// Bench for multi_servo_tester. Two instances share one stimulus: one with no
// slew limit and one with SLEW_US=5. A frame-level reference model predicts
// each pulse width, and a pin monitor measures every pulse and every period.
module tb_multi_servo_tester;

  localparam int CH        = 3;
  localparam int MHZ       = 4;
  localparam int FRAME     = 200;
  localparam int MIN       = 50;
  localparam int MAX       = 150;
  localparam int CENTER    = 100;
  localparam int STEP      = 10;
  localparam int SLEW      = 5;
  localparam int FRAME_CYC = FRAME * MHZ;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_up = 1'b0;
  logic          step_dn = 1'b0;
  logic          ch_next = 1'b0;
  logic [CH-1:0] pins0, pins1;
  logic [3:0]    sel0, sel1;
  logic [15:0]   len0, len1;
  logic [2*CH-1:0] pins_all;

  assign pins_all = {pins1, pins0};

  multi_servo_tester #(
    .CHANNELS(CH), .CLK_MHZ(MHZ), .FRAME_US(FRAME), .MIN_US(MIN), .MAX_US(MAX),
    .CENTER_US(CENTER), .STEP_US(STEP), .SLEW_US(0)
  ) u_fast (
    .CLK(clk), .RST_N(rst_n), .step_up(step_up), .step_dn(step_dn), .ch_next(ch_next),
    .CONTROL_PINS(pins0), .SEL(sel0), .PULSE_LEN(len0)
  );

  multi_servo_tester #(
    .CHANNELS(CH), .CLK_MHZ(MHZ), .FRAME_US(FRAME), .MIN_US(MIN), .MAX_US(MAX),
    .CENTER_US(CENTER), .STEP_US(STEP), .SLEW_US(SLEW)
  ) u_slew (
    .CLK(clk), .RST_N(rst_n), .step_up(step_up), .step_dn(step_dn), .ch_next(ch_next),
    .CONTROL_PINS(pins1), .SEL(sel1), .PULSE_LEN(len1)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model (frame level) ----------------
  int m_target [CH];
  int m_cur    [2][CH];
  int m_sel;
  int m_edges;
  int exp_q    [2*CH][$];   // expected width (us) per frame; index d*CH+ch

  function automatic int toward(input int t, input int c, input int lim);
    if (lim == 0) return t;
    if (t > c) return (t - c > lim) ? c + lim : t;
    if (c > t) return (c - t > lim) ? c - lim : t;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges = 0;
      m_sel   = 0;
      for (int i = 0; i < CH; i++) begin
        m_target[i] = CENTER;
        m_cur[0][i] = CENTER;
        m_cur[1][i] = CENTER;
        exp_q[i].delete();      exp_q[i].push_back(CENTER);
        exp_q[CH+i].delete();   exp_q[CH+i].push_back(CENTER);
      end
    end else begin
      m_edges++;
      if (m_edges % FRAME_CYC == 0) begin
        for (int i = 0; i < CH; i++) begin
          m_cur[0][i] = toward(m_target[i], m_cur[0][i], 0);
          m_cur[1][i] = toward(m_target[i], m_cur[1][i], SLEW);
          exp_q[i].push_back(m_cur[0][i]);
          exp_q[CH+i].push_back(m_cur[1][i]);
        end
      end
      if (step_up && !step_dn)
        m_target[m_sel] = (m_target[m_sel] + STEP > MAX) ? MAX : m_target[m_sel] + STEP;
      else if (step_dn && !step_up)
        m_target[m_sel] = (m_target[m_sel] - STEP < MIN) ? MIN : m_target[m_sel] - STEP;
      if (ch_next) m_sel = (m_sel + 1) % CH;
    end
  end

  // ---------------- pin monitor ----------------
  int          run       [2*CH];
  int          last_rise [2*CH];
  int          ncyc;
  logic [2*CH-1:0] prev_pins;
  int          s_hist[$];   // measured widths (us) of slew instance, channel 0

  always @(negedge clk) begin
    if (!rst_n) begin
      ncyc      = 0;
      prev_pins = '0;
      s_hist.delete();
      for (int k = 0; k < 2*CH; k++) begin
        run[k]       = 0;
        last_rise[k] = -1;
      end
    end else begin
      ncyc++;
      for (int k = 0; k < 2*CH; k++) begin
        if (pins_all[k]) begin
          if (!prev_pins[k]) begin
            if (last_rise[k] >= 0)
              check($sformatf("period d%0d ch%0d", k / CH, k % CH), ncyc - last_rise[k], FRAME_CYC);
            last_rise[k] = ncyc;
          end
          run[k]++;
        end else if (run[k] > 0) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("unexpected pulse d%0d ch%0d", k / CH, k % CH), run[k], 0);
          end else begin
            check($sformatf("width d%0d ch%0d", k / CH, k % CH), run[k], exp_q[k].pop_front() * MHZ);
            if (k == CH) s_hist.push_back(run[k] / MHZ);
          end
          run[k] = 0;
        end
      end
      prev_pins = pins_all;
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    logic up;
    logic dn;
    logic nx;
    int   sel;
    int   len;
    int   hold;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic up, input logic dn, input logic nx,
                              input int sel, input int len, input int hold);
    vec_t v;
    v.up = up; v.dn = dn; v.nx = nx; v.sel = sel; v.len = len; v.hold = hold;
    tbl.push_back(v);
  endfunction

  // One-cycle action, then settle so PULSE_LEN reflects the new state.
  task automatic act(input logic up, input logic dn, input logic nx);
    @(negedge clk);
    step_up = up; step_dn = dn; ch_next = nx;
    @(negedge clk);
    step_up = 1'b0; step_dn = 1'b0; ch_next = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(3);
    check("reset pins fast", int'(pins0), 0);
    check("reset pins slew", int'(pins1), 0);
    check("reset sel", int'(sel0), 0);
    check("reset pulse_len", int'(len0), CENTER);
    check("reset pulse_len slew", int'(len1), CENTER);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit seen;

    // Table: steps, saturation, selection wrap, coincident pulses.
    for (int i = 1; i <= 3; i++) add(1, 0, 0, 0, CENTER + i*STEP, (i == 3) ? 2*FRAME_CYC : 0);
    for (int i = 4; i <= 10; i++) add(1, 0, 0, 0, (CENTER + i*STEP > MAX) ? MAX : CENTER + i*STEP, 0);
    for (int i = 1; i <= 20; i++) add(0, 1, 0, 0, (MAX - i*STEP < MIN) ? MIN : MAX - i*STEP, 0);
    add(0, 0, 1, 1, 100, 0);
    add(0, 0, 1, 2, 100, 0);
    add(1, 0, 0, 2, 110, 0);
    add(0, 0, 1, 0,  50, 0);
    add(1, 0, 1, 1, 100, 0);   // step applies to ch0 (50 -> 60), then select ch1
    add(0, 0, 1, 2, 110, 0);
    add(0, 0, 1, 0,  60, 0);
    add(1, 1, 0, 0,  60, 0);   // both directions at once: no change
    add(0, 1, 1, 1, 100, 0);   // ch0 60 -> 50, select ch1
    add(0, 0, 1, 2, 110, 0);
    add(0, 0, 1, 0,  50, 0);

    // 1: reset state and three idle frames at centre width.
    do_reset();
    idle(3 * FRAME_CYC);
    check("idle sel", int'(sel0), 0);
    check("idle pulse_len", int'(len0), CENTER);

    // 2-4: table vectors, starting mid-frame.
    idle(200);
    for (int i = 0; i < tbl.size(); i++) begin
      act(tbl[i].up, tbl[i].dn, tbl[i].nx);
      check($sformatf("tbl[%0d] sel", i), int'(sel0), tbl[i].sel);
      check($sformatf("tbl[%0d] pulse_len", i), int'(len0), tbl[i].len);
      check($sformatf("tbl[%0d] pulse_len slew", i), int'(len1), tbl[i].len);
      idle(tbl[i].hold);
    end
    idle(3 * FRAME_CYC);

    // 5: slew-limited ramp on ch0, 100 -> 150 in 5 us steps per frame.
    do_reset();
    repeat (5) act(1, 0, 0);
    check("ramp target", int'(len1), 150);
    idle(12 * FRAME_CYC + 100);
    check("ramp frames seen", (s_hist.size() >= 12) ? 1 : 0, 1);
    for (int k = 0; k < 12; k++) begin
      if (k < s_hist.size())
        check($sformatf("ramp frame %0d", k), s_hist[k], (CENTER + 5*k > 150) ? 150 : CENTER + 5*k);
    end

    // 6: reset asserted in the middle of a 140 us pulse.
    act(0, 1, 0);
    check("pre-reset pulse_len", int'(len0), 140);
    idle(3 * FRAME_CYC);
    seen = 0;
    for (int c = 0; c < 2 * FRAME_CYC && !seen; c++) begin
      @(negedge clk);
      if (pins0[0]) seen = 1;
    end
    check("pin0 pulse found", int'(seen), 1);
    idle(100);
    check("pin0 high mid-pulse", int'(pins0[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async drop fast", int'(pins0), 0);
    check("async drop slew", int'(pins1), 0);
    do_reset();
    idle(3 * FRAME_CYC);
    check("post-reset sel", int'(sel0), 0);
    check("post-reset pulse_len", int'(len0), CENTER);

    // Randomized actions against the model.
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: act(1, 0, 0);
        4, 5, 6:    act(0, 1, 0);
        7:          act(0, 0, 1);
        8:          act(1, 1, 0);
        default:    act(1, 0, 1);
      endcase
      check("rand sel", int'(sel0), m_sel);
      check("rand pulse_len", int'(len0), m_target[m_sel]);
      check("rand pulse_len slew", int'(len1), m_target[m_sel]);
      idle(int'($urandom_range(0, 60)));
    end
    idle(3 * FRAME_CYC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
